// File: rtl/param_data_memory.sv
// Parameterised single-port data memory with byte enables, a one-cycle
// read response, out-of-range flagging and an optional zero-fill after reset.
module param_data_memory #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_be,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_busy
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    localparam state_t RESET_STATE = (INIT_CLEAR != 0) ? CLEAR : READY;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_addr;
    logic                accept;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    clr_idx;
    logic [DATA_W-1:0]   mem [DEPTH];

    assign accept   = req_valid && req_ready;
    assign in_range = (32'(req_addr) < 32'(DEPTH));
    assign idx      = req_addr[IDX_W-1:0];
    assign clr_idx  = clr_addr[IDX_W-1:0];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: leave CLEAR once the last word has been zeroed
    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_addr == LAST_ADDR) state_next = READY;
            READY:   state_next = READY;
            default: state_next = RESET_STATE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        req_ready = (state == READY);
        init_busy = (state == CLEAR);
    end

    // Clear address walks 0..DEPTH-1 while in CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            clr_addr <= (clr_addr == LAST_ADDR) ? '0 : clr_addr + 1'b1;
        end
    end

    // Memory array: zero-fill in CLEAR, byte-enabled writes in READY (no reset)
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state == CLEAR) begin
                mem[clr_idx] <= '0;
            end else if (accept && req_write && in_range) begin
                for (int unsigned i = 0; i < BYTES; i++) begin
                    if (req_be[i]) begin
                        mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
                    end
                end
            end
        end
    end

    // Read response registered one cycle after acceptance; zero when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else if (accept && !req_write) begin
            rsp_valid <= 1'b1;
            rsp_err   <= !in_range;
            rsp_rdata <= in_range ? mem[idx] : '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end
    end

endmodule

// File: tb/tb_param_data_memory.sv
// Self-checking bench for param_data_memory against an array-based model.
module tb_param_data_memory;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 12;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic                req_write = 1'b0;
    logic [ADDR_W-1:0]   req_addr = '0;
    logic [DATA_W-1:0]   req_wdata = '0;
    logic [1:0]          req_be = '0;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_err;
    logic                init_busy;

    int passed = 0;
    int total  = 0;

    logic [15:0] model [DEPTH];

    always #5 clk = ~clk;

    param_data_memory #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .DEPTH      (DEPTH),
        .INIT_CLEAR (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_busy (init_busy)
    );

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = 16'h0000;
    endtask

    task automatic model_write(input int a, input logic [15:0] d, input logic [1:0] be);
        if (a < DEPTH) begin
            if (be[0]) model[a][7:0]  = d[7:0];
            if (be[1]) model[a][15:8] = d[15:8];
        end
    endtask

    function automatic logic [17:0] exp_read(input int a);
        if (a < DEPTH) return {1'b1, 1'b0, model[a]};
        return {1'b1, 1'b1, 16'h0000};
    endfunction

    function automatic logic [17:0] observed();
        return {rsp_valid, rsp_err, rsp_rdata};
    endfunction

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic drive_cycle(input logic v, input logic w, input int a,
                               input logic [15:0] d, input logic [1:0] be);
        req_valid = v;
        req_write = w;
        req_addr  = 4'(a);
        req_wdata = d;
        req_be    = be;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive_cycle(1'b0, 1'b0, 0, 16'h0000, 2'b00);
    endtask

    // Counts samples with init_busy high; bad counts samples where ready or a response leaked
    task automatic wait_clear(output int cycles, output int bad);
        cycles = 0;
        bad    = 0;
        while (init_busy === 1'b1 && cycles < 100) begin
            cycles++;
            if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad++;
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int cyc, bad;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if ({init_busy, req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000})
            $display("FAIL reset_state: got busy=%b ready=%b valid=%b err=%b rdata=%h expected 1 0 0 0 0000",
                     init_busy, req_ready, rsp_valid, rsp_err, rsp_rdata);
        else passed++;
        rst_n = 1'b1;
        wait_clear(cyc, bad);
        model_clear();
        total++;
        if (cyc !== DEPTH) $display("FAIL clear_length: got %0d expected %0d", cyc, DEPTH);
        else passed++;
        total++;
        if (bad !== 0 || req_ready !== 1'b1)
            $display("FAIL clear_ready: got bad=%0d ready=%b expected bad=0 ready=1", bad, req_ready);
        else passed++;
        for (int a = 0; a < DEPTH; a++) begin
            drive_cycle(1'b1, 1'b0, a, 16'h0000, 2'b00);
            total++;
            if (observed() !== exp_read(a))
                $display("FAIL clear_read[%0d]: got %h expected %h", a, observed(), exp_read(a));
            else passed++;
        end
        idle_cycle();
        total++;
        if (observed() !== 18'h0) $display("FAIL idle_after_reads: got %h expected 0", observed());
        else passed++;
    endtask

    task automatic test_byte_enable();
        drive_cycle(1'b1, 1'b1, 3, 16'hABCD, 2'b11);
        model_write(3, 16'hABCD, 2'b11);
        total++;
        if (observed() !== 18'h0) $display("FAIL write_no_rsp: got %h expected 0", observed());
        else passed++;
        drive_cycle(1'b1, 1'b1, 3, 16'h1234, 2'b01);
        model_write(3, 16'h1234, 2'b01);
        drive_cycle(1'b1, 1'b0, 3, 16'h0000, 2'b00);
        total++;
        if (observed() !== exp_read(3) || rsp_rdata !== 16'hAB34)
            $display("FAIL byte_enable: got %h expected %h", observed(), exp_read(3));
        else passed++;
        idle_cycle();
    endtask

    task automatic test_read_after_write();
        drive_cycle(1'b1, 1'b1, 5, 16'h00FF, 2'b11);
        model_write(5, 16'h00FF, 2'b11);
        total++;
        if (rsp_valid !== 1'b0) $display("FAIL raw_early: got valid=%b expected 0", rsp_valid);
        else passed++;
        drive_cycle(1'b1, 1'b0, 5, 16'h0000, 2'b00);
        total++;
        if (observed() !== exp_read(5))
            $display("FAIL raw_read: got %h expected %h", observed(), exp_read(5));
        else passed++;
        for (int a = 5; a <= 7; a++) begin
            drive_cycle(1'b1, 1'b0, a, 16'h0000, 2'b00);
            total++;
            if (observed() !== exp_read(a))
                $display("FAIL back_to_back[%0d]: got %h expected %h", a, observed(), exp_read(a));
            else passed++;
        end
        idle_cycle();
        total++;
        if (observed() !== 18'h0) $display("FAIL b2b_single_pulse: got %h expected 0", observed());
        else passed++;
    endtask

    task automatic test_out_of_range();
        drive_cycle(1'b1, 1'b1, 13, 16'hFFFF, 2'b11);
        model_write(13, 16'hFFFF, 2'b11);
        total++;
        if (observed() !== 18'h0) $display("FAIL oor_write_rsp: got %h expected 0", observed());
        else passed++;
        drive_cycle(1'b1, 1'b0, 13, 16'h0000, 2'b00);
        total++;
        if (observed() !== exp_read(13))
            $display("FAIL oor_read: got %h expected %h", observed(), exp_read(13));
        else passed++;
        for (int a = 0; a < DEPTH; a++) begin
            drive_cycle(1'b1, 1'b0, a, 16'h0000, 2'b00);
            total++;
            if (observed() !== exp_read(a))
                $display("FAIL oor_unchanged[%0d]: got %h expected %h", a, observed(), exp_read(a));
            else passed++;
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_clear();
        int cyc, bad;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        total++;
        if (init_busy !== 1'b1) $display("FAIL mid_clear_busy: got %b expected 1", init_busy);
        else passed++;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        wait_clear(cyc, bad);
        model_clear();
        total++;
        if (cyc !== DEPTH || bad !== 0)
            $display("FAIL clear_restart: got cycles=%0d bad=%0d expected cycles=%0d bad=0", cyc, bad, DEPTH);
        else passed++;
    endtask

    task automatic test_read_in_flight();
        int cyc, bad;
        drive_cycle(1'b1, 1'b1, 4, 16'h1111, 2'b11);
        model_write(4, 16'h1111, 2'b11);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 4'd4;
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (observed() !== 18'h0) $display("FAIL inflight_drop: got %h expected 0", observed());
        else passed++;
        req_valid = 1'b0;
        rst_n = 1'b1;
        wait_clear(cyc, bad);
        model_clear();
        total++;
        if (cyc !== DEPTH) $display("FAIL inflight_clear: got %0d expected %0d", cyc, DEPTH);
        else passed++;
        drive_cycle(1'b1, 1'b0, 4, 16'h0000, 2'b00);
        total++;
        if (observed() !== exp_read(4))
            $display("FAIL rsp_before_reset: got %h expected %h", observed(), exp_read(4));
        else passed++;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (observed() !== 18'h0) $display("FAIL rsp_async_drop: got %h expected 0", observed());
        else passed++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wait_clear(cyc, bad);
        model_clear();
    endtask

    task automatic test_clear_ignore();
        int cyc, bad;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 4'd2;
        req_wdata = 16'h5555;
        req_be    = 2'b11;
        rst_n = 1'b1;
        wait_clear(cyc, bad);
        req_valid = 1'b0;
        model_clear();
        total++;
        if (cyc !== DEPTH || bad !== 0)
            $display("FAIL clear_ignore_len: got cycles=%0d bad=%0d expected cycles=%0d bad=0", cyc, bad, DEPTH);
        else passed++;
        drive_cycle(1'b1, 1'b0, 2, 16'h0000, 2'b00);
        total++;
        if (observed() !== exp_read(2))
            $display("FAIL clear_ignore_word: got %h expected %h", observed(), exp_read(2));
        else passed++;
        idle_cycle();
    endtask

    task automatic test_random();
        int op, a;
        logic [15:0] d;
        logic [1:0]  be;
        logic [17:0] exp;
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, 15));
            d  = 16'($urandom);
            be = 2'($urandom_range(0, 3));
            if (op == 0) begin
                exp = 18'h0;
                drive_cycle(1'b0, 1'b0, a, d, be);
            end else if (op == 1) begin
                exp = 18'h0;
                drive_cycle(1'b1, 1'b1, a, d, be);
                model_write(a, d, be);
            end else begin
                exp = exp_read(a);
                drive_cycle(1'b1, 1'b0, a, d, be);
            end
            total++;
            if (observed() !== exp)
                $display("FAIL random[%0d] op=%0d addr=%0d: got %h expected %h", n, op, a, observed(), exp);
            else passed++;
        end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_byte_enable();
        test_read_after_write();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        test_read_in_flight();
        test_clear_ignore();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width; legal values are multiples of 8, minimum 8.
REQ-002 The block SHALL have parameter ADDR_W, default 8, address width.
REQ-003 The block SHALL have parameter DEPTH, default 256, number of words; legal range is 1 to 2**ADDR_W.
REQ-004 The block SHALL have parameter INIT_CLEAR, default 1; 1 enables zero-fill of all words after reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit: a request is presented this cycle.
REQ-008 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-009 The block SHALL have port req_write, input, 1 bit: 1 = write, 0 = read.
REQ-010 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-011 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-012 The block SHALL have port req_be, input, DATA_W/8 bits: byte enables; bit i enables byte [8i+7:8i].
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: a read response is presented this cycle.
REQ-014 The block SHALL have port rsp_rdata, output, DATA_W bits: read data.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: the responded read was out of range.
REQ-016 The block SHALL have port init_busy, output, 1 bit: the zero-fill is in progress.

Function
REQ-017 The FSM SHALL have two states, CLEAR and READY; req_ready SHALL be 1 only in READY and init_busy SHALL be 1 only in CLEAR.
REQ-018 In CLEAR, the block SHALL write zero to word clr_addr each cycle, starting at 0 and incrementing by 1; when clr_addr equals DEPTH-1, the next state SHALL be READY, so CLEAR lasts exactly DEPTH cycles.
REQ-019 Request handshake: a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1; when req_valid is 1 but the request is not accepted, it SHALL be ignored with no side effects.
REQ-020 Accepted write with req_addr < DEPTH: the block SHALL update only the bytes whose req_be bit is 1, in the same edge; bytes with req_be bit 0 SHALL retain their value.
REQ-021 Accepted write with req_addr >= DEPTH: the block SHALL modify no word and SHALL produce no response.
REQ-022 Accepted read: rsp_valid SHALL be 1 for exactly one cycle, the cycle after acceptance (latency 1); rsp_rdata SHALL carry the word value as of the acceptance edge, after any write in an earlier cycle.
REQ-023 Out-of-range read (req_addr >= DEPTH): the response SHALL have rsp_valid=1, rsp_err=1 and rsp_rdata=0.
REQ-024 When rsp_valid is 0, rsp_rdata and rsp_err SHALL both be 0.
REQ-025 Back-to-back reads SHALL be supported, one accepted per cycle, with one response per cycle.
REQ-026 A read accepted one cycle after a write to the same address SHALL return the newly written bytes.
REQ-027 There SHALL be no response backpressure; every response SHALL be presented once.
REQ-028 The block SHALL accept only one request per cycle (single port); there is no simultaneous read/write case.

Reset
REQ-029 While rst_n is 0, the block SHALL hold: state CLEAR if INIT_CLEAR=1, else READY; clr_addr=0; rsp_valid=0; rsp_rdata=0; rsp_err=0.
REQ-030 Memory array contents SHALL NOT be asynchronously reset; with INIT_CLEAR=0, contents after reset are undefined.
REQ-031 Reset asserted mid-CLEAR or mid-read SHALL abort the operation, drop any pending response, and restart the clear from address 0 after release.

Verification
REQ-032 Bench parameters: DATA_W=16, ADDR_W=4, DEPTH=12, INIT_CLEAR=1.
REQ-033 Reset release -> init_busy=1 and req_ready=0 for exactly 12 cycles, then req_ready=1; reads of words 0..11 -> rsp_rdata=0x0000, rsp_err=0.
REQ-034 Write addr 3, data 0xABCD, be=2'b11; then write addr 3, data 0x1234, be=2'b01; then read addr 3 -> rsp_rdata=0xAB34.
REQ-035 Write addr 5, data 0x00FF, then read addr 5 on the next cycle -> rsp_valid=1 exactly one cycle later with rsp_rdata=0x00FF; reads of addr 5, 6, 7 issued back-to-back -> three consecutive rsp_valid cycles.
REQ-036 Write addr 13, data 0xFFFF, then read addr 13 -> rsp_err=1 and rsp_rdata=0; words 0..11 are unchanged.
REQ-037 rst_n pulsed low while clr_addr=6 -> CLEAR restarts at 0 and init_busy stays 1 for a full 12 cycles after release; a read in flight when rst_n falls -> no rsp_valid.
REQ-038 req_valid=1 during CLEAR with a write to addr 2, data 0x5555 -> the request is ignored, and word 2 reads 0x0000 after CLEAR completes.
